// File: rtl/aes128_encrypt_iter.sv
//-----------------------------------------------------------------------------
// aes128_encrypt_iter
//   Iterative AES-128 encryption core, one full round per clock.
//   A block is accepted in IDLE (round-0 AddRoundKey applied on capture),
//   rounds 1..10 run in RUN with round keys expanded on the fly, and the
//   result is presented in DONE until the downstream handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : plaintext/keystate present
//   in_ready   : core idle, block accepted when in_valid is also high
//   plaintext  : input block, [127:120] = byte 0, column-major
//   keystate   : cipher key, same byte order
//   out_valid  : ciphertext/last_key valid
//   out_ready  : downstream accepts the ciphertext
//   ciphertext : encrypted block
//   last_key   : round-10 key, seeds the inverse key schedule
//-----------------------------------------------------------------------------
module aes128_encrypt_iter #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] keystate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] last_key
);

    if (NR != 10) begin : g_bad_nr
        $error("aes128_encrypt_iter: NR must be 10 for AES-128");
    end

    localparam logic [3:0] LAST = 4'(NR);

    // Round constants indexed by round number; entries 0 and 11..15 unused.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1b, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] lk_q, lk_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Data path: SubBytes then ShiftRows (row r rotated left by r columns).
    logic [7:0]   sb_data [16];
    logic [127:0] shifted;
    logic [127:0] mixed;

    for (genvar n = 0; n < 16; n++) begin : g_dsbox
        aes128_sbox u_sbox (
            .in_i  (state_q[127-8*n -: 8]),
            .out_o (sb_data[n])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127-8*(r+4*c) -: 8] = sb_data[r + 4*((c + r) % 4)];
        end
        assign mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
    end

    // Key path: RotWord + SubWord of the last key word, then XOR Rcon.
    logic [31:0]  sub_w;
    logic [31:0]  temp_w;
    logic [127:0] key_next;

    for (genvar j = 0; j < 4; j++) begin : g_ksbox
        aes128_sbox u_sbox (
            .in_i  (key_q[127-8*(12 + ((j + 1) % 4)) -: 8]),
            .out_o (sub_w[31-8*j -: 8])
        );
    end

    assign temp_w = sub_w ^ {RCON[round_q], 24'h000000};

    always_comb begin
        key_next[127:96] = key_q[127:96] ^ temp_w;
        key_next[95:64]  = key_q[95:64]  ^ key_next[127:96];
        key_next[63:32]  = key_q[63:32]  ^ key_next[95:64];
        key_next[31:0]   = key_q[31:0]   ^ key_next[63:32];
    end

    logic         last_round;
    logic [127:0] round_out;

    assign last_round = (round_q == LAST);
    assign round_out  = (last_round ? shifted : mixed) ^ key_next;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        ct_d    = ct_q;
        lk_d    = lk_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ keystate;
                    key_d   = keystate;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (round_q > LAST) begin
                    // Unreachable counter value: abandon the block.
                    round_d = '0;
                    fsm_d   = IDLE;
                end else begin
                    key_d   = key_next;
                    state_d = round_out;
                    round_d = round_q + 4'd1;
                    if (last_round) begin
                        ct_d    = round_out;
                        lk_d    = key_next;
                        round_d = '0;
                        fsm_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
            lk_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            lk_q    <= lk_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign ciphertext = ct_q;
    assign last_key   = lk_q;

endmodule

//-----------------------------------------------------------------------------
// aes128_sbox
//   Forward AES S-box as a 256-entry lookup table.
//   in_i  : input byte
//   out_o : substituted byte
//-----------------------------------------------------------------------------
module aes128_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
module tb_aes128_encrypt_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] keystate;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [127:0] last_key;

    aes128_encrypt_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .keystate   (keystate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .last_key   (last_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];
    logic [7:0] rc  [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned k);
        logic [15:0] d;
        d = {b, b};
        return d[15-k -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int unsigned x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int unsigned y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int unsigned x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int unsigned i = 2; i < 11; i++) rc[i] = gmul(rc[i-1], 8'h02);
    endtask

    function automatic logic [7:0] byt(input logic [127:0] b, input int unsigned n);
        return b[127-8*n -: 8];
    endfunction

    task automatic model_enc(input logic [127:0] pt, input logic [127:0] key,
                             output logic [127:0] ct, output logic [127:0] lk);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] w [4];
        logic [7:0] a [4];
        for (int unsigned n = 0; n < 16; n++) begin
            k[n] = byt(key, n);
            s[n] = byt(pt, n) ^ k[n];
        end
        for (int unsigned rnd = 1; rnd <= 10; rnd++) begin
            w[0] = sb[k[13]] ^ rc[rnd];
            w[1] = sb[k[14]];
            w[2] = sb[k[15]];
            w[3] = sb[k[12]];
            for (int unsigned n = 0; n < 16; n++) begin
                if (n < 4) k[n] = k[n] ^ w[n];
                else       k[n] = k[n] ^ k[n-4];
            end
            for (int unsigned n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    s[r+4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    for (int unsigned i = 0; i < 4; i++) a[i] = s[4*c+i];
                    s[4*c+0] = gmul(a[0],2) ^ gmul(a[1],3) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gmul(a[1],2) ^ gmul(a[2],3) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2],2) ^ gmul(a[3],3);
                    s[4*c+3] = gmul(a[0],3) ^ a[1] ^ a[2] ^ gmul(a[3],2);
                end
            end
            for (int unsigned n = 0; n < 16; n++) s[n] = s[n] ^ k[n];
        end
        for (int unsigned n = 0; n < 16; n++) begin
            ct[127-8*n -: 8] = s[n];
            lk[127-8*n -: 8] = k[n];
        end
    endtask

    // Inverse cipher seeded by the round-10 key (what the decrypt side does).
    task automatic model_dec(input logic [127:0] ct, input logic [127:0] lk,
                             output logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] a [4];
        for (int unsigned n = 0; n < 16; n++) begin
            k[n] = byt(lk, n);
            s[n] = byt(ct, n);
        end
        for (int unsigned rnd = 10; rnd >= 1; rnd--) begin
            for (int unsigned n = 0; n < 16; n++) s[n] = s[n] ^ k[n];
            if (rnd < 10) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    for (int unsigned i = 0; i < 4; i++) a[i] = s[4*c+i];
                    s[4*c+0] = gmul(a[0],14) ^ gmul(a[1],11) ^ gmul(a[2],13) ^ gmul(a[3],9);
                    s[4*c+1] = gmul(a[0],9)  ^ gmul(a[1],14) ^ gmul(a[2],11) ^ gmul(a[3],13);
                    s[4*c+2] = gmul(a[0],13) ^ gmul(a[1],9)  ^ gmul(a[2],14) ^ gmul(a[3],11);
                    s[4*c+3] = gmul(a[0],11) ^ gmul(a[1],13) ^ gmul(a[2],9)  ^ gmul(a[3],14);
                end
            end
            for (int unsigned n = 0; n < 16; n++) t[n] = s[n];
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    s[r + 4*((c + r) % 4)] = t[r+4*c];
            for (int unsigned n = 0; n < 16; n++) s[n] = isb[s[n]];
            for (int unsigned n = 15; n >= 4; n--) k[n] = k[n] ^ k[n-4];
            k[0] = k[0] ^ sb[k[13]] ^ rc[rnd];
            k[1] = k[1] ^ sb[k[14]];
            k[2] = k[2] ^ sb[k[15]];
            k[3] = k[3] ^ sb[k[12]];
        end
        for (int unsigned n = 0; n < 16; n++) pt[127-8*n -: 8] = s[n] ^ k[n];
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge. Accepts one block, checks latency,
    // results and the output handshake.
    task automatic run_block(input string nm, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_ct, input logic [127:0] exp_lk,
                             output logic [127:0] got_ct, output logic [127:0] got_lk);
        int unsigned n;
        out_ready = 1'b1;
        plaintext = pt;
        keystate  = key;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk({nm, " ready"}, 128'(in_ready), 128'd1);
        step();
        in_valid  = 1'b0;
        plaintext = rnd128();
        keystate  = rnd128();
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk({nm, " latency"}, 128'(n), 128'd10);
        got_ct = ciphertext;
        got_lk = last_key;
        chk({nm, " ct"}, got_ct, exp_ct);
        chk({nm, " last_key"}, got_lk, exp_lk);
        step();
        chk({nm, " handshake {out_valid,in_ready}"}, 128'({out_valid, in_ready}), 128'b01);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] lk;
    } vec_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        vec_t         tbl [2];
        logic [127:0] gct, glk, mct, mlk, dpt, ct1, hold_ct, hold_lk;
        int unsigned  n;
        bit           bad, seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        keystate  = '0;
        build_tables();

        tbl[0] = '{key: KEY_B, pt: PT_B, ct: CT_B, lk: LK_B};
        tbl[1] = '{key: KEY_C, pt: PT_C, ct: CT_C, lk: LK_C};

        // Reset state.
        #12;
        chk("reset {in_ready,out_valid}", 128'({in_ready, out_valid}), 128'b10);
        chk("reset ciphertext", ciphertext, '0);
        chk("reset last_key", last_key, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Known-answer vectors, model sanity and decrypt loopback.
        for (int unsigned i = 0; i < 2; i++) begin
            model_enc(tbl[i].pt, tbl[i].key, mct, mlk);
            chk($sformatf("model kat%0d", i), mct, tbl[i].ct);
            run_block($sformatf("kat%0d", i), tbl[i].pt, tbl[i].key, tbl[i].ct, tbl[i].lk, gct, glk);
            model_dec(gct, glk, dpt);
            chk($sformatf("kat%0d loopback", i), dpt, tbl[i].pt);
        end

        // Random blocks against the model.
        for (int unsigned i = 0; i < 12; i++) begin
            logic [127:0] rp, rk;
            rp = rnd128();
            rk = rnd128();
            model_enc(rp, rk, mct, mlk);
            run_block($sformatf("rand%0d", i), rp, rk, mct, mlk, gct, glk);
        end

        // Backpressure: out_ready low for 20 cycles after out_valid.
        out_ready = 1'b0;
        plaintext = PT_B;
        keystate  = KEY_B;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("bp latency", 128'(n), 128'd10);
        hold_ct = ciphertext;
        hold_lk = last_key;
        chk("bp ct", hold_ct, CT_B);
        bad = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            if (ciphertext !== hold_ct || last_key !== hold_lk || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        chk("bp hold stable", 128'(bad), 128'd0);
        out_ready = 1'b1;
        step();
        chk("bp handshake {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'b01);
        step();
        chk("bp single handshake out_valid", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid held high; the second block is driven
        // during the first run and must not disturb it.
        out_ready = 1'b1;
        plaintext = PT_B;
        keystate  = KEY_B;
        in_valid  = 1'b1;
        step();
        plaintext = PT_C;
        keystate  = KEY_C;
        n = 0;
        seen = 1'b0;
        ct1 = '0;
        while (!in_ready && n < 40) begin
            step();
            n++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                ct1 = ciphertext;
            end
        end
        chk("b2b first ct", ct1, CT_B);
        chk("b2b acceptance gap", 128'(n + 1), 128'd12);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("b2b second latency", 128'(n), 128'd10);
        chk("b2b second ct", ciphertext, CT_C);
        step();

        // Asynchronous reset in the middle of round 5.
        plaintext = PT_B;
        keystate  = KEY_B;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst {in_ready,out_valid}", 128'({in_ready, out_valid}), 128'b10);
        chk("midrst ciphertext", ciphertext, '0);
        chk("midrst last_key", last_key, '0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        bad = 1'b0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
            step();
        end
        chk("post-reset idle", 128'(bad), 128'd0);
        run_block("post-reset kat", PT_B, KEY_B, CT_B, LK_B, gct, glk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption core; the forward counterpart of the team's decryption round datapath.
- Performs one full AES round per clock: SubBytes, ShiftRows, MixColumns, then AddRoundKey.
- The final round omits MixColumns.
- Round keys are expanded on the fly from the cipher key.
- Block data moves in and out on valid/ready handshakes.
- Also outputs the round-10 key, which the decryption side needs to seed its inverse key schedule.

Parameters:
- NR, 10, number of rounds. Only 10 is legal (AES-128); any other value is a synthesis-time error.

Ports:
- clk  input  1  single clock; all flops rise-edge triggered.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext and key present.
- in_ready  output  1  core idle and able to accept a block.
- plaintext  input  128  block; bits [127:120] = byte 0 (s0,0), column-major per FIPS-197.
- keystate  input  128  cipher key, same byte order as plaintext.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts the ciphertext.
- ciphertext  output  128  encrypted block.
- last_key  output  128  round-10 key; valid whenever out_valid is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state register, key register, round counter, ciphertext and last_key all clear to 0.
  - out_valid clears to 0; FSM goes to IDLE.
  - in_ready reads 1 (decoded from IDLE), but no input is captured while rst_n is low.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, at the accepting edge:
    - state <= plaintext ^ keystate (round 0 AddRoundKey);
    - key register <= keystate; round <= 1; go to RUN.
  - RUN: in_ready=0. Each edge:
    - key <= KeyExpand(key, Rcon[round]);
    - state <= Round(state, new key), with MixColumns skipped when round==10;
    - round <= round+1.
    - After the round-10 edge: ciphertext <= result, last_key <= round-10 key, go to DONE.
  - DONE: out_valid=1; ciphertext and last_key held stable. When out_valid && out_ready at an edge: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises exactly 10 cycles after the accepting edge.
  - in_ready returns 1 in the cycle after the output handshake.
  - Minimum spacing between accepted blocks is 12 cycles.
- KeyExpand: w' = RotWord then SubWord of the last word, XOR Rcon.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
  - Rcon is held in a 4-bit-indexed lookup table, not computed.
- S-box: the forward S-box table (shared table style with the inverse S-box).
  - 16 instances for the data path, 4 for the key path.
- Backpressure:
  - out_ready low holds DONE indefinitely with outputs unchanged.
  - in_valid is ignored outside IDLE; plaintext and keystate are sampled only on the accepting edge and may change afterwards.
- Simultaneous events:
  - in_valid during DONE with out_ready high is not accepted that cycle; it is accepted the next cycle in IDLE.
  - out_ready while not in DONE has no effect.
- Reset mid-operation:
  - Any asserted rst_n low, in any state, aborts immediately.
  - No partial ciphertext and no out_valid pulse follow reset release.
- round counter: 4 bits, never exceeds 10; values 11..15 are unreachable, and the FSM returns to IDLE if it ever sees one.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32; out_valid asserted exactly 10 cycles after acceptance.
  - Required: last_key d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Loopback: feed ciphertext and last_key to the decryption chain; it must recover the pt.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid rises.
  - Required: ciphertext and last_key constant; in_ready=0 throughout; single handshake when out_ready rises; in_ready=1 next cycle.
- Input ignored while busy:
  - Stimulus: drive in_valid with a different pt/key during cycles 1..10 of a run.
  - Required: first result unchanged (3925841d...); second block accepted only after return to IDLE.
- Reset mid-run:
  - Stimulus: assert rst_n low asynchronously (between edges) at round 5.
  - Required: out_valid=0, ciphertext=0 immediately; after release in_ready=1, no spurious out_valid; next App. B block encrypts correctly.
- Back-to-back:
  - Stimulus: in_valid held high, out_ready=1, two blocks (App. B then App. C.1).
  - Required: acceptances 12 cycles apart, both ciphertexts correct and in order.
